writeback_arbiter: RTL and testbench
====================================

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: register-file write-data width.
REQ-002 Parameter REG_ADDR_WIDTH, default 5: register-file write-address width.
REQ-003 Parameter STARVE_LIMIT, default 4: consecutive lost-arbitration cycles (range 2..15) after which a queued side write is forced.
REQ-004 CLK  input  1  the single clock; all state updates on its rising edge.
REQ-005 RST  input  1  asynchronous, active-low reset.
REQ-006 RegWriteW  input  1  writeback-stage write enable.
REQ-007 WriteRegW  input  REG_ADDR_WIDTH  writeback-stage destination register.
REQ-008 ResultW  input  DATA_WIDTH  writeback-stage result.
REQ-009 SideValid  input  1  multi-cycle unit (mul/div) write request.
REQ-010 SideAddr  input  REG_ADDR_WIDTH  side-request destination register.
REQ-011 SideData  input  DATA_WIDTH  side-request data.
REQ-012 SideReady  output  1  arbiter accepts the side request this cycle.
REQ-013 RFWriteEn  output  1  register-file write enable.
REQ-014 RFWriteAddr  output  REG_ADDR_WIDTH  register-file write address.
REQ-015 RFWriteData  output  DATA_WIDTH  register-file write data.
REQ-016 StallW  output  1  hold the writeback stage (its inputs are re-presented next cycle).
REQ-017 SidePending  output  1  side queue non-empty.

Function
REQ-018 The block SHALL contain a 2-entry FIFO for side writes; a side transfer occurs when SideValid and SideReady are both 1 at a rising edge.
REQ-019 SideReady SHALL be 1 exactly when the FIFO count, registered, is below 2; it SHALL NOT depend on same-cycle dequeue.
REQ-020 A side transfer with SideAddr = 0 SHALL be accepted and discarded, without being enqueued.
REQ-021 A pipeline write is active when RegWriteW = 1 and WriteRegW != 0; a write with WriteRegW = 0 SHALL leave the port free.
REQ-022 The FSM SHALL have two states: PIPE_PRI and FORCE.
REQ-023 In PIPE_PRI: an active pipeline write SHALL drive the port (RFWriteEn = 1, WriteRegW, ResultW) and StallW = 0. Otherwise, if the FIFO is non-empty, the FIFO head SHALL drive the port and be dequeued. Otherwise RFWriteEn = 0.
REQ-024 In FORCE with the FIFO non-empty: the FIFO head SHALL drive the port and be dequeued. StallW SHALL equal the active-pipeline-write condition, and the pipeline write SHALL NOT reach the port.
REQ-025 The starvation counter (4 bits) SHALL increment each PIPE_PRI cycle in which the FIFO is non-empty and no dequeue occurs. It SHALL clear on any dequeue or when the FIFO is empty.
REQ-026 Transition PIPE_PRI->FORCE SHALL occur at the edge where the counter would reach STARVE_LIMIT. FORCE->PIPE_PRI SHALL occur after exactly one FORCE cycle, or immediately if the FIFO is empty in FORCE.
REQ-027 Enqueue and dequeue in the same cycle SHALL leave the count unchanged and keep FIFO order.
REQ-028 Pointers SHALL wrap modulo 2.
REQ-029 Port-to-register latency SHALL be zero: the port outputs are combinational from the current state, FIFO head and inputs.
REQ-030 A write accepted at edge N SHALL be eligible to drive the port from cycle N+1; there is no bypass of an empty FIFO.
REQ-031 SidePending SHALL be 1 exactly when the FIFO count is not 0.

Reset
REQ-032 While RST = 0, the block SHALL hold:
- FIFO count, pointers and starvation counter = 0;
- state = PIPE_PRI;
- RFWriteEn = 0, StallW = 0, SideReady = 0, SidePending = 0;
- RFWriteAddr and RFWriteData = 0.
REQ-033 Reset asserted mid-operation SHALL discard queued side writes; no port write SHALL occur until the first edge after RST deasserts.

Verification
REQ-034 Idle pipeline; side write (addr 7, 0xDEADBEEF) at edge N -> at cycle N+1, RFWriteEn = 1, addr 7, data 0xDEADBEEF; SidePending falls after edge N+1.
REQ-035 Three back-to-back side requests while the pipeline writes continuously -> SideReady = 0 after the 2nd accept; the 3rd transfer does not complete until a dequeue.
REQ-036 Pipeline writes every cycle with 1 queued entry, STARVE_LIMIT = 4 -> after 4 starved cycles, one FORCE cycle: StallW = 1, FIFO entry written; the next cycle returns to pipeline priority.
REQ-037 Pipeline RegWriteW = 1 with WriteRegW = 0, FIFO holds (addr 3, 0x5) -> the FIFO entry is written that cycle and StallW = 0.
REQ-038 Side request with addr 0 -> accepted, SidePending stays 0, RFWriteEn never driven by it.
REQ-039 Two entries queued, RST pulsed low mid-cycle -> all outputs 0 immediately; after release, no stale write appears.

Source files
------------

// File: rtl/writeback_arbiter_if.sv
// Writeback-port bundle: pipeline writeback inputs, side (mul/div) request
// handshake, and the shared register-file write port.
interface writeback_arbiter_if #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5
);
   logic                      RegWriteW;
   logic [REG_ADDR_WIDTH-1:0] WriteRegW;
   logic [DATA_WIDTH-1:0]     ResultW;
   logic                      SideValid;
   logic [REG_ADDR_WIDTH-1:0] SideAddr;
   logic [DATA_WIDTH-1:0]     SideData;
   logic                      SideReady;
   logic                      RFWriteEn;
   logic [REG_ADDR_WIDTH-1:0] RFWriteAddr;
   logic [DATA_WIDTH-1:0]     RFWriteData;
   logic                      StallW;
   logic                      SidePending;

   modport master (
      output RegWriteW, WriteRegW, ResultW, SideValid, SideAddr, SideData,
      input  SideReady, RFWriteEn, RFWriteAddr, RFWriteData, StallW, SidePending
   );

   modport slave (
      input  RegWriteW, WriteRegW, ResultW, SideValid, SideAddr, SideData,
      output SideReady, RFWriteEn, RFWriteAddr, RFWriteData, StallW, SidePending
   );
endinterface

// File: rtl/writeback_arbiter.sv
// Shares one register-file write port between the writeback stage and a
// 2-entry side-write FIFO, forcing a side write after STARVE_LIMIT lost cycles.
module writeback_arbiter #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int STARVE_LIMIT   = 4
) (
   input logic                CLK,
   input logic                RST,
   writeback_arbiter_if.slave wb
);
   typedef enum logic {PIPE_PRI, FORCE} state_t;

   typedef struct packed {
      logic [REG_ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0]     data;
   } entry_t;

   localparam logic [3:0] STARVE_LAST = 4'(STARVE_LIMIT - 1);

   state_t     state;
   entry_t     mem [2];
   logic       wr_ptr;
   logic       rd_ptr;
   logic [1:0] count;
   logic [3:0] starve;

   logic   pipe_active;
   logic   has_entry;
   logic   take_side;
   logic   ready;
   logic   enq;
   logic   deq;
   entry_t head;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      pipe_active = 1'b0;
      has_entry   = 1'b0;
      take_side   = 1'b0;
      ready       = 1'b0;
      enq         = 1'b0;
      deq         = 1'b0;
      head        = mem[rd_ptr];
      pipe_active = wb.RegWriteW && (wb.WriteRegW != '0);
      has_entry   = (count != 2'd0);
      take_side   = has_entry && ((state == FORCE) || !pipe_active);
      ready       = RST && (count != 2'd2);
      enq         = wb.SideValid && ready && (wb.SideAddr != '0);
      deq         = take_side;
   end

   // Port is combinational; everything is gated by RST so reset silences it at once.
   assign wb.SideReady   = ready;
   assign wb.SidePending = has_entry;
   assign wb.RFWriteEn   = RST && (take_side || pipe_active);
   assign wb.StallW      = RST && (state == FORCE) && has_entry && pipe_active;
   assign wb.RFWriteAddr = !RST      ? '0 :
                           take_side ? head.addr :
                           pipe_active ? wb.WriteRegW : '0;
   assign wb.RFWriteData = !RST      ? '0 :
                           take_side ? head.data :
                           pipe_active ? wb.ResultW : '0;

   // NOTE: FIFO storage is not reset; count and pointers alone define which entries are valid.
   always_ff @(posedge CLK) begin
      if (enq) mem[wr_ptr] <= '{addr: wb.SideAddr, data: wb.SideData};
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state  <= PIPE_PRI;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
         starve <= 4'd0;
      end else begin
         if (enq) wr_ptr <= ~wr_ptr;
         if (deq) rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, enq} - {1'b0, deq};

         case (state)
            PIPE_PRI: begin
               if (has_entry && !deq) begin
                  if (starve == STARVE_LAST) begin
                     state  <= FORCE;
                     starve <= 4'd0;
                  end else begin
                     starve <= starve + 4'd1;
                  end
               end else begin
                  starve <= 4'd0;
               end
            end
            FORCE: begin
               state  <= PIPE_PRI;
               starve <= 4'd0;
            end
            default: state <= PIPE_PRI;
         endcase
      end
   end
endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized and directed stimulus checked against a queue-based model of the
// writeback port arbitration rules.
module tb_writeback_arbiter;
   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int LIMIT = 4;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } entry_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   entry_t q[$];
   int     lost_cycles = 0;
   bit     force_now = 1'b0;

   writeback_arbiter_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) bus ();

   writeback_arbiter #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
      .CLK(clk),
      .RST(rst_n),
      .wb (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive_idle();
      bus.RegWriteW = 1'b0;
      bus.WriteRegW = '0;
      bus.ResultW   = '0;
      bus.SideValid = 1'b0;
      bus.SideAddr  = '0;
      bus.SideData  = '0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_en"},      DW'(bus.RFWriteEn),   '0);
      check({tag, "_addr"},    DW'(bus.RFWriteAddr), '0);
      check({tag, "_data"},    bus.RFWriteData,      '0);
      check({tag, "_stall"},   DW'(bus.StallW),      '0);
      check({tag, "_ready"},   DW'(bus.SideReady),   '0);
      check({tag, "_pending"}, DW'(bus.SidePending), '0);
   endtask

   // One clock cycle: apply inputs after the edge, check against the model,
   // then advance the model to what the next edge commits.
   task automatic step(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic sv, input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                       output logic accepted, output logic stalled);
      bit            pipe, exp_en, exp_stall, exp_ready, serve_queue;
      logic [AW-1:0] exp_addr;
      logic [DW-1:0] exp_data;
      @(posedge clk);
      #1;
      bus.RegWriteW = we;
      bus.WriteRegW = wa;
      bus.ResultW   = wd;
      bus.SideValid = sv;
      bus.SideAddr  = sa;
      bus.SideData  = sd;
      #1;
      pipe        = we && (wa != 0);
      exp_ready   = q.size() < 2;
      serve_queue = (q.size() > 0) && (force_now || !pipe);
      exp_stall   = (q.size() > 0) && force_now && pipe;
      exp_en      = serve_queue || pipe;
      exp_addr    = serve_queue ? q[0].addr : wa;
      exp_data    = serve_queue ? q[0].data : wd;

      check("side_ready",   DW'(bus.SideReady),   DW'(exp_ready));
      check("side_pending", DW'(bus.SidePending), DW'(q.size() > 0));
      check("rf_en",        DW'(bus.RFWriteEn),   DW'(exp_en));
      check("stall",        DW'(bus.StallW),      DW'(exp_stall));
      if (exp_en) begin
         check("rf_addr", DW'(bus.RFWriteAddr), DW'(exp_addr));
         check("rf_data", bus.RFWriteData,      exp_data);
      end

      accepted = sv && exp_ready;
      stalled  = exp_stall;
      if (force_now) begin
         force_now   = 1'b0;
         lost_cycles = 0;
      end else if (q.size() > 0 && !serve_queue) begin
         lost_cycles++;
         if (lost_cycles == LIMIT) begin
            force_now   = 1'b1;
            lost_cycles = 0;
         end
      end else begin
         lost_cycles = 0;
      end
      if (serve_queue) void'(q.pop_front());
      if (accepted && sa != 0) q.push_back('{addr: sa, data: sd});
   endtask

   initial begin
      logic          acc, stl;
      logic          we;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      int            side_n;

      // Reset held with busy inputs: everything must be silent.
      bus.RegWriteW = 1'b1;
      bus.WriteRegW = 5'd5;
      bus.ResultW   = 32'h1234;
      bus.SideValid = 1'b1;
      bus.SideAddr  = 5'd6;
      bus.SideData  = 32'h55;
      #12;
      check_all_zero("reset");
      drive_idle();
      @(negedge clk);
      rst_n = 1'b1;

      // Idle pipeline, single side write appears on the port one cycle later.
      step(0, 0, 0, 1, 5'd7, 32'hDEADBEEF, acc, stl);
      step(0, 0, 0, 0, 0, 0, acc, stl);
      step(0, 0, 0, 0, 0, 0, acc, stl);

      // Pipeline busy every cycle; producer holds three requests until accepted,
      // then starvation forces the queued entries out.
      side_n = 0;
      for (int i = 0; i < 20; i++) begin
         step(1, 5'd1 + 5'(i % 30), 32'h100 + i, side_n < 3, 5'd10 + 5'(side_n),
              32'hA0 + side_n, acc, stl);
         if (acc) side_n++;
      end
      check("three_accepted", DW'(side_n), DW'(3));

      // Queue (3, 0x5) behind a busy pipeline, then RegWriteW with WriteRegW = 0.
      step(1, 5'd4, 32'h44, 1, 5'd3, 32'h5, acc, stl);
      step(1, 5'd0, 32'h99, 0, 0, 0, acc, stl);
      step(0, 0, 0, 0, 0, 0, acc, stl);

      // Side request to register 0 is swallowed.
      step(0, 0, 0, 1, 5'd0, 32'hBAD, acc, stl);
      check("addr0_accepted", DW'(acc), DW'(1));
      step(0, 0, 0, 0, 0, 0, acc, stl);

      // Randomized traffic; a stalled writeback re-presents its inputs.
      stl = 1'b0;
      we = 1'b0; wa = '0; wd = '0;
      for (int i = 0; i < 3000; i++) begin
         if (!stl) begin
            we = ($urandom_range(0, 9) < 8);
            wa = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            wd = $urandom;
         end
         step(we, wa, wd, $urandom_range(0, 1) == 1,
              ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
              $urandom, acc, stl);
      end

      // Fill both entries behind a busy pipeline, then reset mid-cycle.
      step(1, 5'd2, 32'h22, 0, 0, 0, acc, stl);
      step(1, 5'd2, 32'h22, 0, 0, 0, acc, stl);
      step(1, 5'd2, 32'h22, 0, 0, 0, acc, stl);
      step(1, 5'd2, 32'h22, 0, 0, 0, acc, stl);
      step(1, 5'd2, 32'h22, 0, 0, 0, acc, stl);
      step(1, 5'd8, 32'h81, 1, 5'd20, 32'hC1, acc, stl);
      step(1, 5'd8, 32'h82, 1, 5'd21, 32'hC2, acc, stl);
      step(1, 5'd8, 32'h83, 1, 5'd22, 32'hC3, acc, stl);
      check("two_queued", DW'(q.size()), DW'(2));
      #3;
      rst_n = 1'b0;
      #1;
      check_all_zero("mid_reset");
      drive_idle();
      @(negedge clk);
      rst_n = 1'b1;
      q.delete();
      lost_cycles = 0;
      force_now   = 1'b0;
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, acc, stl);
      step(0, 0, 0, 1, 5'd9, 32'h77, acc, stl);
      step(0, 0, 0, 0, 0, 0, acc, stl);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
